// File: rtl/rf_pkg.sv
// Shared defaults and elaboration-time helpers for the banked register file.
package rf_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_NREGS  = 4;
  localparam int DEF_NBANKS = 2;

  // Number of address bits needed to index n entries.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rf_bank.sv
// One register bank: NREGS general registers plus a masked-write flag register.
module rf_bank #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  parameter int AW    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic             fw_i,
  input  logic [WIDTH-1:0] fd_i,
  input  logic [WIDTH-1:0] fm_i,
  input  logic [AW-1:0]    ra_i,
  input  logic [AW-1:0]    rb_i,
  output logic [WIDTH-1:0] rda_o,
  output logic [WIDTH-1:0] rdb_o,
  output logic [WIDTH-1:0] f_o
);

  localparam logic [AW:0] NREGS_L = (AW+1)'(NREGS);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] f_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      f_q <= '0;
    end else begin
      // Addresses past NREGS are silently dropped when NREGS is not a power of two.
      if (we_i && ({1'b0, wa_i} < NREGS_L)) regs_q[wa_i] <= wd_i;
      if (fw_i) f_q <= (f_q & ~fm_i) | (fd_i & fm_i);
    end
  end

  assign rda_o = ({1'b0, ra_i} < NREGS_L) ? regs_q[ra_i] : '0;
  assign rdb_o = ({1'b0, rb_i} < NREGS_L) ? regs_q[rb_i] : '0;
  assign f_o   = f_q;

endmodule

// File: rtl/rf_banked.sv
// Banked register file: NBANKS register/flag banks, one active at a time,
// with registered dual read ports, write-to-read bypass and acked bank switching.
module rf_banked
  import rf_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NREGS  = DEF_NREGS,
  parameter int NBANKS = DEF_NBANKS,
  localparam int AW    = clog2(NREGS),
  localparam int BW    = (NBANKS > 1) ? clog2(NBANKS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    wa,
  input  logic [WIDTH-1:0] wd,
  input  logic             re,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  output logic [WIDTH-1:0] qa,
  output logic [WIDTH-1:0] qb,
  input  logic             fw,
  input  logic [WIDTH-1:0] fd,
  input  logic [WIDTH-1:0] fm,
  output logic [WIDTH-1:0] fo,
  output logic [WIDTH-1:0] fod,
  input  logic             sw_req,
  input  logic [BW-1:0]    sw_bank,
  output logic             sw_ack,
  output logic [BW-1:0]    bank
);

  localparam logic [AW:0] NREGS_L  = (AW+1)'(NREGS);
  localparam logic [BW:0] NBANKS_L = (BW+1)'(NBANKS);

  logic [WIDTH-1:0] rda_w [NBANKS];
  logic [WIDTH-1:0] rdb_w [NBANKS];
  logic [WIDTH-1:0] f_w   [NBANKS];

  logic [BW-1:0]    bank_q;
  logic             ack_q;
  logic [WIDTH-1:0] qa_q, qa_d;
  logic [WIDTH-1:0] qb_q, qb_d;
  logic [WIDTH-1:0] fod_q;
  logic             sw_ok;

  // Only the active bank sees write strobes; a switch takes effect after the edge.
  for (genvar g = 0; g < NBANKS; g++) begin : g_bank
    rf_bank #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_bank (
      .clk_i (clk),
      .rst_i (rst),
      .we_i  (we && (bank_q == BW'(g))),
      .wa_i  (wa),
      .wd_i  (wd),
      .fw_i  (fw && (bank_q == BW'(g))),
      .fd_i  (fd),
      .fm_i  (fm),
      .ra_i  (ra),
      .rb_i  (rb),
      .rda_o (rda_w[g]),
      .rdb_o (rdb_w[g]),
      .f_o   (f_w[g])
    );
  end

  assign sw_ok = sw_req && ({1'b0, sw_bank} < NBANKS_L);

  always_comb begin
    qa_d = '0;
    qb_d = '0;
    if ({1'b0, ra} < NREGS_L) qa_d = (we && (wa == ra)) ? wd : rda_w[bank_q];
    if ({1'b0, rb} < NREGS_L) qb_d = (we && (wa == rb)) ? wd : rdb_w[bank_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_q <= '0;
      ack_q  <= 1'b0;
      qa_q   <= '0;
      qb_q   <= '0;
      fod_q  <= '0;
    end else begin
      if (re) begin
        qa_q <= qa_d;
        qb_q <= qb_d;
      end
      fod_q <= fo;
      ack_q <= sw_ok;
      if (sw_ok) bank_q <= sw_bank;
    end
  end

  assign fo     = f_w[bank_q];
  assign fod    = fod_q;
  assign qa     = qa_q;
  assign qb     = qb_q;
  assign sw_ack = ack_q;
  assign bank   = bank_q;

endmodule

// File: tb/tb_rf_banked.sv
// Randomized + directed bench for rf_banked: three configurations driven in lockstep
// and compared every cycle against an array-based behavioural model.
module tb_rf_banked;

  localparam int NK = 3;
  localparam int NREGS_C  [NK] = '{4, 3, 4};
  localparam int NBANKS_C [NK] = '{2, 3, 1};

  logic       clk = 1'b0;
  logic       rst;
  logic       we, re, fw, sw_req;
  logic [1:0] wa, ra, rb;
  logic [7:0] wd, fd, fm;
  logic [1:0] sw_bank;

  logic [7:0] qa_w [NK];
  logic [7:0] qb_w [NK];
  logic [7:0] fo_w [NK];
  logic [7:0] fod_w[NK];
  logic       ack_w[NK];
  logic [0:0] bank0, bank2;
  logic [1:0] bank1;

  int m_reg  [NK][4][4];
  int m_f    [NK][4];
  int m_bank [NK];
  int m_qa   [NK];
  int m_qb   [NK];
  int m_fod  [NK];
  int m_ack  [NK];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rf_banked #(.WIDTH(8), .NREGS(4), .NBANKS(2)) u_dut0 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra), .rb(rb),
    .qa(qa_w[0]), .qb(qb_w[0]), .fw(fw), .fd(fd), .fm(fm), .fo(fo_w[0]), .fod(fod_w[0]),
    .sw_req(sw_req), .sw_bank(sw_bank[0:0]), .sw_ack(ack_w[0]), .bank(bank0)
  );

  rf_banked #(.WIDTH(8), .NREGS(3), .NBANKS(3)) u_dut1 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra), .rb(rb),
    .qa(qa_w[1]), .qb(qb_w[1]), .fw(fw), .fd(fd), .fm(fm), .fo(fo_w[1]), .fod(fod_w[1]),
    .sw_req(sw_req), .sw_bank(sw_bank), .sw_ack(ack_w[1]), .bank(bank1)
  );

  rf_banked #(.WIDTH(8), .NREGS(4), .NBANKS(1)) u_dut2 (
    .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .re(re), .ra(ra), .rb(rb),
    .qa(qa_w[2]), .qb(qb_w[2]), .fw(fw), .fd(fd), .fm(fm), .fo(fo_w[2]), .fod(fod_w[2]),
    .sw_req(sw_req), .sw_bank(sw_bank[0:0]), .sw_ack(ack_w[2]), .bank(bank2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: applies one clock edge of the specified behaviour to each configuration.
  task automatic model_step();
    for (int k = 0; k < NK; k++) begin
      if (rst) begin
        for (int b = 0; b < 4; b++) begin
          m_f[k][b] = 0;
          for (int r = 0; r < 4; r++) m_reg[k][b][r] = 0;
        end
        m_bank[k] = 0; m_qa[k] = 0; m_qb[k] = 0; m_fod[k] = 0; m_ack[k] = 0;
      end else begin
        int b, nr, sb;
        b  = m_bank[k];
        nr = NREGS_C[k];
        sb = (k == 1) ? int'(sw_bank) : int'(sw_bank[0]);
        if (re) begin
          m_qa[k] = (ra < nr) ? ((we && wa == ra) ? int'(wd) : m_reg[k][b][ra]) : 0;
          m_qb[k] = (rb < nr) ? ((we && wa == rb) ? int'(wd) : m_reg[k][b][rb]) : 0;
        end
        if (we && wa < nr) m_reg[k][b][wa] = int'(wd);
        m_fod[k] = m_f[k][b];
        if (fw) m_f[k][b] = (m_f[k][b] & ~int'(fm) & 255) | (int'(fd) & int'(fm));
        m_ack[k] = (sw_req && sb < NBANKS_C[k]) ? 1 : 0;
        if (m_ack[k] == 1) m_bank[k] = sb;
      end
    end
  endtask

  task automatic compare_all();
    int bk[NK];
    bk[0] = int'(bank0); bk[1] = int'(bank1); bk[2] = int'(bank2);
    for (int k = 0; k < NK; k++) begin
      check($sformatf("qa%0d", k),   qa_w[k],  m_qa[k]);
      check($sformatf("qb%0d", k),   qb_w[k],  m_qb[k]);
      check($sformatf("fo%0d", k),   fo_w[k],  m_f[k][m_bank[k]]);
      check($sformatf("fod%0d", k),  fod_w[k], m_fod[k]);
      check($sformatf("ack%0d", k),  ack_w[k], m_ack[k]);
      check($sformatf("bank%0d", k), bk[k],    m_bank[k]);
    end
  endtask

  // One clock: inputs are already set, model follows the edge, outputs sampled 1ns later.
  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic idle();
    rst = 0; we = 0; re = 0; fw = 0; sw_req = 0;
    wa = 0; ra = 0; rb = 0; wd = 0; fd = 0; fm = 0; sw_bank = 0;
  endtask

  initial begin
    idle();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    cyc();
    check("rst_qa", qa_w[0], 0);
    check("rst_bank", bank0, 0);

    // Write then read
    we = 1; wa = 0; wd = 100; cyc();
    wa = 1; wd = 30; cyc();
    wa = 3; wd = 54; cyc();
    idle(); re = 1; ra = 0; rb = 3; cyc();
    check("rd_qa", qa_w[0], 100);
    check("rd_qb", qb_w[0], 54);
    check("rd_oob_qb", qb_w[1], 0);

    // Same-cycle bypass
    idle(); we = 1; wa = 2; wd = 8'hA5; re = 1; ra = 2; rb = 1; cyc();
    check("byp_qa", qa_w[0], 8'hA5);
    check("byp_qb", qb_w[0], 30);

    // Masked flags
    idle(); fw = 1; fd = 8'hFF; fm = 8'h0F; cyc();
    check("flag_set", fo_w[0], 8'h0F);
    fd = 8'h00; fm = 8'h01; cyc();
    check("flag_clr", fo_w[0], 8'h0E);
    check("flag_fod", fod_w[0], 8'h0F);

    // Bank switch with a write in the switch cycle going to the old bank
    idle(); sw_req = 1; sw_bank = 1; we = 1; wa = 1; wd = 77; cyc();
    check("sw_ack", ack_w[0], 1);
    check("sw_bank", bank0, 1);
    check("sw_nb1_ack", ack_w[2], 0);
    idle(); re = 1; ra = 1; rb = 1; cyc();
    check("sw_new_r1", qa_w[0], 0);
    check("sw_ack_drop", ack_w[0], 0);
    idle(); sw_req = 1; sw_bank = 0; cyc();
    check("sw_back_ack", ack_w[0], 1);
    idle(); re = 1; ra = 1; cyc();
    check("sw_old_r1", qa_w[0], 77);

    // Illegal target bank, back-to-back requests, reset masking a request
    idle(); sw_req = 1; sw_bank = 3; cyc();
    check("bad_sw_ack", ack_w[1], 0);
    check("bad_sw_bank", bank1, 0);
    sw_bank = 2; cyc();
    sw_bank = 1; cyc();
    check("b2b_ack", ack_w[1], 1);
    check("b2b_bank", bank1, 1);
    rst = 1; sw_bank = 2; cyc();
    check("rst_ack", ack_w[1], 0);
    check("rst_bank1", bank1, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      we      = $urandom_range(0, 1);
      re      = $urandom_range(0, 1);
      fw      = ($urandom_range(0, 3) == 0);
      sw_req  = ($urandom_range(0, 5) == 0);
      wa      = 2'($urandom_range(0, 3));
      ra      = 2'($urandom_range(0, 3));
      rb      = ($urandom_range(0, 3) == 0) ? wa : 2'($urandom_range(0, 3));
      wd      = 8'($urandom);
      fd      = 8'($urandom);
      fm      = 8'($urandom);
      sw_bank = 2'($urandom_range(0, 3));
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
